// File: rtl/instr_fmt_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : instr_fmt_pkg
//  Description : Shared instruction field layout for the 8-bit processor.
//                Holds the bit positions of every field, the format select
//                codes and the opcode enumeration, so the encoder and the
//                decode stage agree on one definition.
//                Word layout:
//                  register form : [7:5] opcode, [4:3] Rs, [2:0] low field
//                  immediate form: [7:5] opcode, [4:0] 5-bit immediate
//  Revision    : 1.0 - initial release
// ============================================================================
package instr_fmt_pkg;

    localparam int OPC_MSB = 7;
    localparam int OPC_LSB = 5;
    localparam int RS_MSB  = 4;
    localparam int RS_LSB  = 3;
    localparam int LO_MSB  = 2;
    localparam int IMM_MSB = 4;

    localparam logic FMT_REG = 1'b0;
    localparam logic FMT_IMM = 1'b1;

    typedef enum logic [2:0] {
        OP_NOP = 3'd0,
        OP_LD  = 3'd1,
        OP_LDI = 3'd2,
        OP_ST  = 3'd3,
        OP_ADD = 3'd4,
        OP_SUB = 3'd5,
        OP_AND = 3'd6,
        OP_JMP = 3'd7
    } opcode_t;

endpackage : instr_fmt_pkg
`default_nettype wire

// File: rtl/instr_pack.sv
`default_nettype none
// ============================================================================
//  Module      : instr_pack
//  Description : Combinational field packer. Builds an 8-bit instruction
//                word from opcode/register/immediate fields. Fields that do
//                not belong to the selected format are ignored.
//  Ports       : fmt  in  1  0 = register form, 1 = immediate form
//                op   in  3  opcode
//                rs   in  2  Rs field (register form)
//                lo   in  3  low field (register form)
//                imm  in  5  immediate (immediate form)
//                word out 8  packed instruction word
//  Revision    : 1.0 - initial release
// ============================================================================
module instr_pack
    import instr_fmt_pkg::*;
(
    input  logic       fmt,
    input  logic [2:0] op,
    input  logic [1:0] rs,
    input  logic [2:0] lo,
    input  logic [4:0] imm,
    output logic [7:0] word
);

    always_comb begin
        word = '0;
        word[OPC_MSB:OPC_LSB] = op;
        case (fmt)
            FMT_IMM: word[IMM_MSB:0] = imm;
            FMT_REG: begin
                word[RS_MSB:RS_LSB] = rs;
                word[LO_MSB:0]      = lo;
            end
        endcase
    end

endmodule : instr_pack
`default_nettype wire

// File: rtl/instr_encoder_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : instr_encoder_fifo
//  Description : Packs instruction fields into 8-bit words and queues them in
//                a small FIFO presented over a valid/ready handshake.
//                Optional feature macro: ENC_STATS_EN adds an 8-bit wrapping
//                count of popped words (issued_cnt).
//  Ports       : clock      in   1        system clock, rising edge
//                reset_n    in   1        asynchronous active-low reset
//                flush      in   1        synchronous clear (wins over push/pop)
//                in_valid   in   1        field set present
//                in_ready   out  1        a field set can be accepted
//                in_fmt     in   1        0 = register form, 1 = immediate form
//                in_op      in   3        opcode
//                in_rs      in   2        Rs field
//                in_lo      in   3        low field
//                in_imm     in   5        immediate
//                out_valid  out  1        instr holds a valid word
//                out_ready  in   1        consumer takes the word
//                instr      out  8        FIFO head word (0 when empty)
//                issued_cnt out  8        pop count (ENC_STATS_EN only)
//                level      out  PTR_W+1  current occupancy
//  Revision    : 1.0 - initial release
// ============================================================================
module instr_encoder_fifo
    import instr_fmt_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_fmt,
    input  logic [2:0]       in_op,
    input  logic [1:0]       in_rs,
    input  logic [2:0]       in_lo,
    input  logic [4:0]       in_imm,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [7:0]       instr,
`ifdef ENC_STATS_EN
    output logic [7:0]       issued_cnt,
`endif
    output logic [PTR_W:0]   level
);

    localparam logic [PTR_W:0] FULL_LEVEL = (PTR_W + 1)'(DEPTH);

    logic [7:0]       packed_word;
    logic [7:0]       mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             push;
    logic             pop;

    instr_pack u_pack (
        .fmt  (in_fmt),
        .op   (in_op),
        .rs   (in_rs),
        .lo   (in_lo),
        .imm  (in_imm),
        .word (packed_word)
    );

    // Readiness is a pure function of the occupancy register, so a full FIFO
    // never accepts a word even when the consumer pops in the same cycle.
    assign in_ready  = (level != FULL_LEVEL);
    assign out_valid = (level != '0);
    assign instr     = out_valid ? mem[rd_ptr] : 8'h00;

    // Flush discards any push or pop attempted in the same cycle.
    assign push = in_valid && in_ready && !flush;
    assign pop  = out_valid && out_ready && !flush;

    // Storage has no reset; entries are only visible once counted in level.
    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr] <= packed_word;
        end
    end

    // DEPTH is a power of two, so natural pointer overflow gives the
    // DEPTH-1 -> 0 wrap.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   level <= level + (PTR_W + 1)'(1);
                2'b01:   level <= level - (PTR_W + 1)'(1);
                default: level <= level;
            endcase
        end
    end

`ifdef ENC_STATS_EN
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            issued_cnt <= 8'h00;
        end else if (flush) begin
            issued_cnt <= 8'h00;
        end else if (pop) begin
            issued_cnt <= issued_cnt + 8'h01;
        end
    end
`endif

endmodule : instr_encoder_fifo
`default_nettype wire

// File: tb/tb_instr_encoder_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : tb_instr_encoder_fifo
//  Description : Self-checking bench for instr_encoder_fifo. Directed steps
//                plus randomized traffic, compared against a queue-based
//                reference model. Honors ENC_STATS_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_encoder_fifo;

    localparam int DEPTH = 4;

    logic       clock = 1'b0;
    logic       reset_n;
    logic       flush;
    logic       in_valid;
    logic       in_ready;
    logic       in_fmt;
    logic [2:0] in_op;
    logic [1:0] in_rs;
    logic [2:0] in_lo;
    logic [4:0] in_imm;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] instr;
    logic [2:0] level;
`ifdef ENC_STATS_EN
    logic [7:0] issued_cnt;
`endif

    int total = 0;
    int bad   = 0;

    logic [7:0] model_q[$];
    int         model_cnt = 0;

    always #5 clock = ~clock;

    instr_encoder_fifo #(.DEPTH(DEPTH)) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_fmt     (in_fmt),
        .in_op      (in_op),
        .in_rs      (in_rs),
        .in_lo      (in_lo),
        .in_imm     (in_imm),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .instr      (instr),
`ifdef ENC_STATS_EN
        .issued_cnt (issued_cnt),
`endif
        .level      (level)
    );

    function automatic logic [7:0] ref_pack(logic f, logic [2:0] op, logic [1:0] rs,
                                            logic [2:0] lo, logic [4:0] imm);
        int v;
        if (f) v = op * 32 + imm;
        else   v = op * 32 + rs * 8 + lo;
        return v[7:0];
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(string tag);
        int n;
        n = model_q.size();
        chk({tag, ".level"}, 32'(level), 32'(n));
        chk({tag, ".out_valid"}, 32'(out_valid), 32'(n != 0));
        chk({tag, ".in_ready"}, 32'(in_ready), 32'(n != DEPTH));
        chk({tag, ".instr"}, 32'(instr), (n != 0) ? 32'(model_q[0]) : 32'h0);
`ifdef ENC_STATS_EN
        chk({tag, ".issued_cnt"}, 32'(issued_cnt), 32'(model_cnt));
`endif
    endtask

    // Advance one clock edge, update the model from the inputs seen at that
    // edge, then check all outputs shortly after the edge.
    task automatic cycle(string tag);
        logic [7:0] w;
        bit acc, tk;
        w   = ref_pack(in_fmt, in_op, in_rs, in_lo, in_imm);
        acc = in_valid && (model_q.size() < DEPTH);
        tk  = out_ready && (model_q.size() > 0);
        @(posedge clock);
        if (flush) begin
            model_q.delete();
            model_cnt = 0;
        end else begin
            if (tk) begin
                void'(model_q.pop_front());
                model_cnt = (model_cnt + 1) % 256;
            end
            if (acc) model_q.push_back(w);
        end
        #1;
        check_all(tag);
    endtask

    task automatic set_reg(logic [2:0] op, logic [1:0] rs, logic [2:0] lo);
        in_fmt = 1'b0; in_op = op; in_rs = rs; in_lo = lo; in_imm = 5'h0;
    endtask

    task automatic set_imm(logic [2:0] op, logic [4:0] imm);
        in_fmt = 1'b1; in_op = op; in_imm = imm; in_rs = 2'b11; in_lo = 3'b111;
    endtask

    initial begin
        reset_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        set_reg(3'd0, 2'd0, 3'd0);

        // Reset values
        #3;
        check_all("reset");
        #9 reset_n = 1'b1;

        // Register form push, then pop
        set_reg(3'b101, 2'b10, 3'b011);
        in_valid = 1'b1;
        cycle("reg_push");
        chk("reg_word", 32'(instr), 32'hB3);
        in_valid = 1'b0; out_ready = 1'b1;
        cycle("reg_pop");
        chk("reg_pop_valid", 32'(out_valid), 32'h0);
        out_ready = 1'b0;

        // Immediate form; Rs/low fields held at all ones
        set_imm(3'b010, 5'h1F);
        in_valid = 1'b1;
        cycle("imm_push");
        chk("imm_word", 32'(instr), 32'h5F);
        in_valid = 1'b0; out_ready = 1'b1;
        cycle("imm_pop");
        out_ready = 1'b0;

        // Fill to full under back-pressure
        for (int i = 1; i <= 4; i++) begin
            set_imm(3'd0, 5'(i));
            in_valid = 1'b1;
            cycle("fill");
        end
        chk("full_level", 32'(level), 32'd4);
        chk("full_in_ready", 32'(in_ready), 32'd0);
        set_imm(3'd0, 5'h05);
        cycle("fifth_rejected");
        // Popping while full still must not let the held word in
        out_ready = 1'b1;
        cycle("full_pop_push");
        chk("full_pop_level", 32'(level), 32'd3);
        in_valid = 1'b0;
        for (int i = 2; i <= 4; i++) begin
            chk("drain_order", 32'(instr), 32'(i));
            cycle("drain");
        end
        chk("drained_empty", 32'(out_valid), 32'd0);
        out_ready = 1'b0;

        // Simultaneous push/pop at level 2
        in_valid = 1'b1;
        set_reg(3'd1, 2'd1, 3'd1); cycle("lvl2_a");
        set_reg(3'd2, 2'd2, 3'd2); cycle("lvl2_b");
        out_ready = 1'b1;
        set_reg(3'd3, 2'd3, 3'd3); cycle("simul");
        chk("simul_level", 32'(level), 32'd2);

        // Randomized mixed traffic, wraps pointers many times
        for (int i = 0; i < 60; i++) begin
            in_valid  = 1'($urandom_range(0, 1));
            out_ready = 1'($urandom_range(0, 1));
            in_fmt    = 1'($urandom_range(0, 1));
            in_op     = 3'($urandom);
            in_rs     = 2'($urandom);
            in_lo     = 3'($urandom);
            in_imm    = 5'($urandom);
            cycle("random");
        end

        // Flush at level 3 with a concurrent push
        in_valid = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 6; i++) cycle("pre_flush_drain");
        out_ready = 1'b0; in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            set_imm(3'd7, 5'(i + 10));
            cycle("pre_flush_fill");
        end
        chk("pre_flush_level", 32'(level), 32'd3);
        flush = 1'b1;
        cycle("flush");
        flush = 1'b0; in_valid = 1'b0;
        chk("flush_level", 32'(level), 32'd0);
        cycle("post_flush_idle");

        // Three pushes and three pops, then async reset mid-stream
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            set_reg(3'(i), 2'(i), 3'(i));
            cycle("stat_fill");
        end
        in_valid = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 3; i++) cycle("stat_pop");
`ifdef ENC_STATS_EN
        chk("stat_cnt3", 32'(issued_cnt), 32'd3);
`endif
        out_ready = 1'b0; in_valid = 1'b1;
        set_imm(3'd4, 5'h0A); cycle("pre_rst_a");
        set_imm(3'd4, 5'h0B); cycle("pre_rst_b");
        #2 reset_n = 1'b0;
        model_q.delete();
        model_cnt = 0;
        #1;
        check_all("async_reset");
        in_valid = 1'b0;
        #2 reset_n = 1'b1;
        cycle("post_reset");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_instr_encoder_fifo
`default_nettype wire
